lane_reorder_am_remove: RTL and testbench

Downstream consumer of the lane reorder sequencer in the 100GbE PCS receive path. Takes the deskewed 20-lane coded-block column and the per-position lane-select bus, then captures a stable select map once reordering has settled. Applies a registered crossbar so output position k carries physical lane select[k]. Strips alignment-marker columns, checks their period, and presents the reordered data columns to the descrambler/decoder.

---
 rtl/lane_reorder_am_remove.sv | 199 +++++++++++++++++++
 tb/tb_lane_reorder_am_remove.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/lane_reorder_am_remove.sv
// Lane reorder crossbar with alignment-marker removal and AM period checking for the 100GbE PCS receive path.
// Optional select-map permutation check is enabled by defining LANE_SELECT_CHECK_EN.
module lane_reorder_am_remove #(
    parameter int LEN_CODED_BLOCK = 66,
    parameter int N_LANES         = 20,
    parameter int NB_ID           = $clog2(N_LANES),
    parameter int NB_BUS_ID       = N_LANES * NB_ID,
    parameter int NB_DATA_BUS     = N_LANES * LEN_CODED_BLOCK,
    parameter int AM_BLOCK_PERIOD = 16383,
    parameter int NB_ERR_CNT      = 8
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic                   i_enable,
    input  logic                   i_valid,
    input  logic                   i_lanes_deskewed,
    input  logic [NB_BUS_ID-1:0]   i_lane_select,
    input  logic [NB_DATA_BUS-1:0] i_data,
    input  logic                   i_am_flag,
    output logic [NB_DATA_BUS-1:0] o_data,
    output logic                   o_valid,
    output logic                   o_locked,
    output logic                   o_am_error,
    output logic [NB_ERR_CNT-1:0]  o_am_err_count,
    output logic                   o_select_error
);

    localparam int NB_FILL = $clog2(N_LANES + 1);
    localparam int NB_PER  = $clog2(AM_BLOCK_PERIOD + 2);

    typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

    state_t                   state_reg, state_next;
    logic [NB_FILL-1:0]       fill_cnt_reg, fill_cnt_next;
    logic                     capture;
    logic                     select_ok;
    logic                     run_active;
    logic [NB_BUS_ID-1:0]     sel_reg;
    logic [NB_DATA_BUS-1:0]   s1_data_reg;
    logic                     s1_am_reg;
    logic                     s1_valid_reg;
    logic [NB_DATA_BUS-1:0]   xbar_data;
    logic [NB_PER-1:0]        per_cnt_reg;
    logic                     am_seen_reg;

    // Pipeline and AM logic only operate while locked and deskew still holds.
    assign run_active = i_enable && i_lanes_deskewed && (state_reg == RUN);

`ifdef LANE_SELECT_CHECK_EN
    logic [N_LANES-1:0] seen;
    logic               select_fail;
    logic               select_error_reg;

    // N fields covering all N values means each appears exactly once.
    always_comb begin
        seen = '0;
        for (int k = 0; k < N_LANES; k++) begin
            if ({1'b0, i_lane_select[k*NB_ID +: NB_ID]} < (NB_ID+1)'(N_LANES))
                seen[i_lane_select[k*NB_ID +: NB_ID]] = 1'b1;
        end
    end
    assign select_ok   = &seen;
    assign select_fail = i_enable && i_lanes_deskewed && (state_reg == FILL)
                         && (fill_cnt_reg == NB_FILL'(N_LANES)) && !select_ok;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            select_error_reg <= 1'b0;
        end else if (i_enable) begin
            if (!i_lanes_deskewed || capture)
                select_error_reg <= 1'b0;
            else if (select_fail)
                select_error_reg <= 1'b1;
        end
    end
    assign o_select_error = select_error_reg;
`else
    assign select_ok      = 1'b1;
    assign o_select_error = 1'b0;
`endif

    always_comb begin
        state_next    = state_reg;
        fill_cnt_next = fill_cnt_reg;
        capture       = 1'b0;
        if (i_enable) begin
            if (!i_lanes_deskewed) begin
                state_next = IDLE;
            end else begin
                case (state_reg)
                    IDLE: begin
                        state_next    = FILL;
                        fill_cnt_next = '0;
                    end
                    FILL: begin
                        if (fill_cnt_reg == NB_FILL'(N_LANES)) begin
                            if (select_ok) begin
                                capture    = 1'b1;
                                state_next = RUN;
                            end else begin
                                fill_cnt_next = '0;
                            end
                        end else if (i_valid) begin
                            fill_cnt_next = fill_cnt_reg + 1'b1;
                        end
                    end
                    RUN:     state_next = RUN;
                    default: state_next = IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_reg    <= IDLE;
            fill_cnt_reg <= '0;
            o_locked     <= 1'b0;
        end else if (i_enable) begin
            state_reg    <= state_next;
            fill_cnt_reg <= fill_cnt_next;
            o_locked     <= (state_next == RUN);
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_LANES; gi++) begin : g_xbar
            logic [LEN_CODED_BLOCK-1:0] s1_lane;
            logic [NB_ID-1:0]           sel;
            assign sel = sel_reg[gi*NB_ID +: NB_ID];
            // Out-of-range select values produce an all-zero block.
            always_comb begin
                s1_lane = '0;
                for (int n = 0; n < N_LANES; n++) begin
                    if ({1'b0, sel} == (NB_ID+1)'(n))
                        s1_lane = s1_data_reg[n*LEN_CODED_BLOCK +: LEN_CODED_BLOCK];
                end
            end
            assign xbar_data[gi*LEN_CODED_BLOCK +: LEN_CODED_BLOCK] = s1_lane;
        end
    endgenerate

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            sel_reg      <= '0;
            s1_data_reg  <= '0;
            s1_am_reg    <= 1'b0;
            s1_valid_reg <= 1'b0;
            o_data       <= '0;
            o_valid      <= 1'b0;
        end else if (i_enable) begin
            if (capture)
                sel_reg <= i_lane_select;
            if (run_active) begin
                s1_valid_reg <= i_valid;
                if (i_valid) begin
                    s1_data_reg <= i_data;
                    s1_am_reg   <= i_am_flag;
                end
                o_valid <= s1_valid_reg && !s1_am_reg;
                if (s1_valid_reg && !s1_am_reg)
                    o_data <= xbar_data;
            end else begin
                s1_valid_reg <= 1'b0;
                o_valid      <= 1'b0;
            end
        end
    end

    // The first AM after lock only establishes the phase; later AMs are checked.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            per_cnt_reg    <= '0;
            am_seen_reg    <= 1'b0;
            o_am_error     <= 1'b0;
            o_am_err_count <= '0;
        end else if (i_enable) begin
            o_am_error <= 1'b0;
            if (capture) begin
                per_cnt_reg <= '0;
                am_seen_reg <= 1'b0;
            end else if (run_active && i_valid) begin
                if (i_am_flag) begin
                    per_cnt_reg <= '0;
                    am_seen_reg <= 1'b1;
                    if (am_seen_reg && (per_cnt_reg != NB_PER'(AM_BLOCK_PERIOD))) begin
                        o_am_error <= 1'b1;
                        if (o_am_err_count != {NB_ERR_CNT{1'b1}})
                            o_am_err_count <= o_am_err_count + 1'b1;
                    end
                end else if (per_cnt_reg != NB_PER'(AM_BLOCK_PERIOD + 1)) begin
                    per_cnt_reg <= per_cnt_reg + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_lane_reorder_am_remove.sv
// Directed bench for lane_reorder_am_remove with a short AM period of 4 columns.
module tb_lane_reorder_am_remove;

    localparam int N   = 20;
    localparam int LEN = 66;
    localparam int NBI = 5;
    localparam int BW  = N * NBI;
    localparam int DW  = N * LEN;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic          valid;
    logic          deskew;
    logic [BW-1:0] sel;
    logic [DW-1:0] data;
    logic          am;
    logic [DW-1:0] o_data;
    logic          o_valid;
    logic          o_locked;
    logic          o_am_error;
    logic [7:0]    o_am_err_count;
    logic          o_select_error;

    int checks = 0;
    int errors = 0;

    lane_reorder_am_remove #(.AM_BLOCK_PERIOD(4)) dut (
        .i_clock(clk), .i_reset(rst), .i_enable(enable), .i_valid(valid),
        .i_lanes_deskewed(deskew), .i_lane_select(sel), .i_data(data),
        .i_am_flag(am), .o_data(o_data), .o_valid(o_valid), .o_locked(o_locked),
        .o_am_error(o_am_error), .o_am_err_count(o_am_err_count),
        .o_select_error(o_select_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        if (obs !== exp) begin
            int k;
            errors++;
            k = 0;
            for (int j = N - 1; j >= 0; j--)
                if (obs[j*LEN +: LEN] !== exp[j*LEN +: LEN]) k = j;
            $display("FAIL %s: slice %0d got %0h expected %0h", tag, k,
                     obs[k*LEN +: LEN], exp[k*LEN +: LEN]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode 0: reverse, 1: rotate by one, 2: reverse with position 0 out of range
    task automatic set_sel(input int mode);
        for (int k = 0; k < N; k++) begin
            if (mode == 1) sel[k*NBI +: NBI] = NBI'((k + 1) % N);
            else           sel[k*NBI +: NBI] = NBI'(N - 1 - k);
        end
        if (mode == 2) sel[0 +: NBI] = 5'd31;
    endtask

    task automatic set_data(input int base);
        for (int n = 0; n < N; n++) data[n*LEN +: LEN] = LEN'(base + n);
    endtask

    function automatic logic [DW-1:0] exp_col(input int base, input int mode);
        logic [DW-1:0] e;
        for (int k = 0; k < N; k++) begin
            if (mode == 1) e[k*LEN +: LEN] = LEN'(base + (k + 1) % N);
            else           e[k*LEN +: LEN] = LEN'(base + N - 1 - k);
        end
        if (mode == 2) e[0 +: LEN] = '0;
        return e;
    endfunction

    task automatic wait_lock(input string tag, input int exp_edges);
        int n;
        n = 0;
        while (n < 60 && !o_locked) begin
            tick();
            n++;
        end
        check(tag, DW'(n), DW'(exp_edges));
    endtask

    task automatic drop_deskew();
        deskew = 1'b0;
        tick();
        check("drop_locked", DW'(o_locked), DW'(0));
        check("drop_valid", DW'(o_valid), DW'(0));
        deskew = 1'b1;
    endtask

    logic seq [15] = '{1,0,0,0,0,1,0,0,0,0,1,0,0,0,1};

    initial begin
        int last_base;
        logic prev;
        rst = 1'b1; enable = 1'b0; valid = 1'b0; deskew = 1'b0; am = 1'b0;
        sel = '0; data = '0;
        tick(); tick();
        check("rst_locked", DW'(o_locked), DW'(0));
        check("rst_valid", DW'(o_valid), DW'(0));
        check("rst_data", o_data, '0);
        check("rst_errcnt", DW'(o_am_err_count), DW'(0));
        check("rst_selerr", DW'(o_select_error), DW'(0));
        rst = 1'b0;

        // First lock with reversed select map
        enable = 1'b1; deskew = 1'b1; valid = 1'b1;
        set_sel(0); set_data(0);
        wait_lock("lock_edges", 22);
        check("lock_selerr", DW'(o_select_error), DW'(0));
        tick();
        check("lat1_valid", DW'(o_valid), DW'(0));
        tick();
        check("lat2_valid", DW'(o_valid), DW'(1));
        check("rev_data", o_data, exp_col(0, 0));

        // Enable low: everything holds
        enable = 1'b0; set_data(500);
        tick(); tick();
        check("hold_valid", DW'(o_valid), DW'(1));
        check("hold_data", o_data, exp_col(0, 0));
        enable = 1'b1; set_data(0);

        // AMs at correct spacing, then one short gap
        last_base = 0;
        for (int i = 0; i < 15; i++) begin
            am = seq[i];
            set_data((i + 1) * 256);
            tick();
            prev = (i > 0) ? seq[i-1] : 1'b0;
            if (!prev && i > 0) last_base = i * 256;
            check($sformatf("seq%0d_amerr", i), DW'(o_am_error), DW'(i == 14));
            check($sformatf("seq%0d_valid", i), DW'(o_valid), DW'(!prev));
            check($sformatf("seq%0d_data", i), o_data, exp_col(last_base, 0));
        end
        check("short_errcnt", DW'(o_am_err_count), DW'(1));
        am = 1'b0;
        tick();
        check("pulse_end", DW'(o_am_error), DW'(0));

        // Missing AM flagged when the late AM arrives
        repeat (9) tick();
        am = 1'b1;
        tick();
        check("late_amerr", DW'(o_am_error), DW'(1));
        check("late_errcnt", DW'(o_am_err_count), DW'(2));

        // Back-to-back AMs drive the counter into saturation
        repeat (298) tick();
        check("sat_errcnt", DW'(o_am_err_count), DW'(255));
        check("sat_amerr", DW'(o_am_error), DW'(1));

        // Deskew drop together with an AM: drop wins
        deskew = 1'b0;
        tick();
        check("dropam_locked", DW'(o_locked), DW'(0));
        check("dropam_valid", DW'(o_valid), DW'(0));
        check("dropam_amerr", DW'(o_am_error), DW'(0));
        check("dropam_errcnt", DW'(o_am_err_count), DW'(255));

        // Relock with a rotated map, then a one-column bubble
        deskew = 1'b1; am = 1'b0;
        set_sel(1); set_data(1000);
        wait_lock("relock_edges", 22);
        tick(); tick();
        check("rot_valid", DW'(o_valid), DW'(1));
        check("rot_data", o_data, exp_col(1000, 1));
        valid = 1'b0;
        tick();
        check("bubble1_valid", DW'(o_valid), DW'(1));
        tick();
        check("bubble2_valid", DW'(o_valid), DW'(0));
        check("bubble_data", o_data, exp_col(1000, 1));
        valid = 1'b1;

`ifndef LANE_SELECT_CHECK_EN
        // Out-of-range select field yields a zero block
        drop_deskew();
        set_sel(2); set_data(2000);
        wait_lock("oor_edges", 22);
        tick(); tick();
        check("oor_data", o_data, exp_col(2000, 2));
`else
        // Duplicate lane 3 is rejected, corrected map locks
        drop_deskew();
        set_sel(0); sel[0 +: NBI] = 5'd3;
        repeat (22) tick();
        check("dup_selerr", DW'(o_select_error), DW'(1));
        check("dup_locked", DW'(o_locked), DW'(0));
        set_sel(0); set_data(3000);
        repeat (20) tick();
        check("retry_locked0", DW'(o_locked), DW'(0));
        tick();
        check("retry_locked1", DW'(o_locked), DW'(1));
        check("retry_selerr", DW'(o_select_error), DW'(0));
        tick(); tick();
        check("retry_data", o_data, exp_col(3000, 0));
`endif

        // Asynchronous reset between clock edges
        check("pre_rst_locked", DW'(o_locked), DW'(1));
        #3;
        rst = 1'b1;
        #1;
        check("arst_locked", DW'(o_locked), DW'(0));
        check("arst_valid", DW'(o_valid), DW'(0));
        check("arst_amerr", DW'(o_am_error), DW'(0));
        check("arst_errcnt", DW'(o_am_err_count), DW'(0));
        check("arst_data", o_data, '0);
        tick();
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
